// File: rtl/smem_pkg.sv
// smem_pkg: shared definitions for the system-memory arbiter.
//   - default address / data widths
//   - FSM state encoding (IDLE, RMW)
//   - requester id encoding (FETCH, DATA)
//   - byte_merge(): combines an old word with new byte lanes under a byte enable
package smem_pkg;

    localparam int AW_DEF  = 10;
    localparam int DW_DEF  = 32;
    localparam int BEW_DEF = DW_DEF / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    // Lane k of the result comes from new_word when be[k] is set, otherwise from old_word.
    function automatic logic [DW_DEF-1:0] byte_merge(
        input logic [DW_DEF-1:0]  old_word,
        input logic [DW_DEF-1:0]  new_word,
        input logic [BEW_DEF-1:0] be
    );
        logic [DW_DEF-1:0] merged;
        merged = old_word;
        for (int k = 0; k < BEW_DEF; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/smem_arb_if.sv
// smem_arb_if: bundles the fetch port, the load/store port and the memory
// port of the system-memory arbiter.
//   slave  modport: the arbiter's view (requests in, grants/responses and
//                   memory commands out, memory read data in)
//   master modport: the requesters' plus memory's view (the mirror image)
interface smem_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();

    // fetch port
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;

    // load/store port
    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    // memory port
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );

endinterface

// File: rtl/smem_rr_pick.sv
// smem_rr_pick: two-request round-robin picker.
//   clk, rst            : clock, synchronous active-high reset
//   hold                : when high no grant is issued and the pointer is kept
//   req_fetch, req_data : requests
//   gnt_fetch, gnt_data : one-hot (or zero) grants, combinational
// On a tie the port that did not win last time is granted; the pointer
// resets to DATA so fetch wins the first tie.
module smem_rr_pick
    import smem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic req_fetch,
    input  logic req_data,
    output logic gnt_fetch,
    output logic gnt_data
);

    req_id_e last_q;
    req_id_e last_d;

    // Grant selection and next last-winner pointer.
    always_comb begin
        gnt_fetch = 1'b0;
        gnt_data  = 1'b0;
        last_d    = last_q;
        if (hold) begin
            gnt_fetch = 1'b0;
            gnt_data  = 1'b0;
        end else if (req_fetch && req_data) begin
            if (last_q == REQ_DATA) begin
                gnt_fetch = 1'b1;
            end else begin
                gnt_data = 1'b1;
            end
        end else if (req_fetch) begin
            gnt_fetch = 1'b1;
        end else if (req_data) begin
            gnt_data = 1'b1;
        end else begin
            gnt_fetch = 1'b0;
            gnt_data  = 1'b0;
        end

        if (gnt_fetch) begin
            last_d = REQ_FETCH;
        end else if (gnt_data) begin
            last_d = REQ_DATA;
        end else begin
            last_d = last_q;
        end
    end

    // Last-winner pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_DATA;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/smem_arb.sv
// smem_arb: round-robin arbiter and sequencer in front of a single-port,
// one-cycle-latency system memory shared by instruction fetch and load/store.
//   clk, rst : clock, synchronous active-high reset
//   bus      : smem_arb_if.slave -- fetch port (i_*), load/store port (d_*),
//              memory port (mem_*)
// Partial-word stores become a read (grant cycle) followed by a merged write
// in the RMW cycle; no request is granted during RMW.
module smem_arb
    import smem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    smem_arb_if.slave      bus
);

    localparam int BEW = DW / 8;
    localparam logic [BEW-1:0] BE_ALL  = {BEW{1'b1}};
    localparam logic [BEW-1:0] BE_NONE = {BEW{1'b0}};

    state_e          state_q,  state_d;
    logic [AW-1:0]   lat_addr_q,  lat_addr_d;
    logic [BEW-1:0]  lat_be_q,    lat_be_d;
    logic [DW-1:0]   lat_wdata_q, lat_wdata_d;
    logic            i_rvalid_q,  i_rvalid_d;
    logic            d_rvalid_q,  d_rvalid_d;

    logic            hold_s;
    logic            i_gnt_s;
    logic            d_gnt_s;
    logic            partial_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [DW-1:0]   mem_din_s;

    // Reset and the RMW write cycle both block new grants.
    assign hold_s = rst | (state_q == ST_RMW);

    smem_rr_pick u_pick (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold_s),
        .req_fetch (bus.i_req),
        .req_data  (bus.d_req),
        .gnt_fetch (i_gnt_s),
        .gnt_data  (d_gnt_s)
    );

    assign partial_s = (bus.d_be != BE_ALL) && (bus.d_be != BE_NONE);

    // Memory command, next FSM state, store latch and response strobes.
    always_comb begin
        state_d     = state_q;
        lat_addr_d  = lat_addr_q;
        lat_be_d    = lat_be_q;
        lat_wdata_d = lat_wdata_q;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_din_s   = {DW{1'b0}};
        if (rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_gnt_s) begin
                        mem_addr_s = bus.i_addr;
                        i_rvalid_d = 1'b1;
                    end else if (d_gnt_s) begin
                        mem_addr_s = bus.d_addr;
                        if (bus.d_we && partial_s) begin
                            // Read the old word now; merge and write next cycle.
                            lat_addr_d  = bus.d_addr;
                            lat_be_d    = bus.d_be;
                            lat_wdata_d = bus.d_wdata;
                            state_d     = ST_RMW;
                        end else begin
                            if (bus.d_we && (bus.d_be == BE_ALL)) begin
                                mem_we_s  = 1'b1;
                                mem_din_s = bus.d_wdata;
                            end else begin
                                mem_we_s  = 1'b0;
                            end
                            d_rvalid_d = 1'b1;
                        end
                    end else begin
                        mem_addr_s = {AW{1'b0}};
                    end
                end
                ST_RMW: begin
                    mem_addr_s = lat_addr_q;
                    mem_we_s   = 1'b1;
                    mem_din_s  = byte_merge(bus.mem_dout, lat_wdata_q, lat_be_q);
                    d_rvalid_d = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, store latch and response-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_addr_q  <= {AW{1'b0}};
            lat_be_q    <= {BEW{1'b0}};
            lat_wdata_q <= {DW{1'b0}};
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_be_q    <= lat_be_d;
            lat_wdata_q <= lat_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign bus.i_gnt    = i_gnt_s;
    assign bus.d_gnt    = d_gnt_s;
    // A response due in a reset cycle is dropped.
    assign bus.i_rvalid = i_rvalid_q & ~rst;
    assign bus.d_rvalid = d_rvalid_q & ~rst;
    assign bus.i_rdata  = bus.mem_dout;
    assign bus.d_rdata  = bus.mem_dout;
    assign bus.mem_we   = mem_we_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_din  = mem_din_s;

endmodule

// File: tb/tb_smem_arb.sv
// tb_smem_arb: self-checking bench for smem_arb with a behavioural memory,
// a spec-level reference model (shadow memory + expected responses) and
// directed plus randomized stimulus.
module tb_smem_arb;

    logic clk;
    logic rst;

    smem_arb_if #(.AW(10), .DW(32)) bus ();

    smem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory with a preload path.
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] smem [1024];

    always @(posedge clk) begin
        if (pl_en) begin
            smem[pl_addr] <= pl_data;
        end else if (bus.mem_we) begin
            smem[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= smem[bus.mem_addr];
    end

    int n_total;
    int n_bad;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [31:0] ref_mem [1024];
    logic        m_last_data;
    logic        m_stall;
    logic [9:0]  m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_pv_i, m_pv_d, m_pv_d_load;
    logic [31:0] m_pv_i_data, m_pv_d_data;
    logic        g_i, g_d;

    // Snapshot of DUT outputs taken at the last checked negedge.
    logic        snap_i_gnt, snap_d_gnt, snap_i_rvalid, snap_d_rvalid, snap_mem_we;
    logic [31:0] snap_i_rdata, snap_d_rdata, snap_mem_din;

    // One clock of checking and model update; inputs are already driven.
    task automatic cycle();
        logic        ei, ed, weexp, part;
        logic [31:0] merged;
        @(negedge clk);
        snap_i_gnt    = bus.i_gnt;
        snap_d_gnt    = bus.d_gnt;
        snap_i_rvalid = bus.i_rvalid;
        snap_d_rvalid = bus.d_rvalid;
        snap_mem_we   = bus.mem_we;
        snap_i_rdata  = bus.i_rdata;
        snap_d_rdata  = bus.d_rdata;
        snap_mem_din  = bus.mem_din;

        ei = 1'b0;
        ed = 1'b0;
        if (!rst && !m_stall) begin
            if (bus.i_req && bus.d_req) begin
                if (m_last_data) ei = 1'b1; else ed = 1'b1;
            end else if (bus.i_req) begin
                ei = 1'b1;
            end else if (bus.d_req) begin
                ed = 1'b1;
            end
        end
        part = (bus.d_be != 4'h0) && (bus.d_be != 4'hF);
        merged = ref_mem[m_addr];
        for (int k = 0; k < 4; k++) begin
            if (m_be[k]) merged[8*k +: 8] = m_wdata[8*k +: 8];
        end

        check_val("i_gnt", {31'd0, bus.i_gnt}, {31'd0, ei});
        check_val("d_gnt", {31'd0, bus.d_gnt}, {31'd0, ed});
        check_val("i_rvalid", {31'd0, bus.i_rvalid}, {31'd0, m_pv_i && !rst});
        check_val("d_rvalid", {31'd0, bus.d_rvalid}, {31'd0, m_pv_d && !rst});
        if (m_pv_i && !rst) check_val("i_rdata", bus.i_rdata, m_pv_i_data);
        if (m_pv_d && m_pv_d_load && !rst) check_val("d_rdata", bus.d_rdata, m_pv_d_data);
        weexp = !rst && (m_stall || (ed && bus.d_we && bus.d_be == 4'hF));
        check_val("mem_we", {31'd0, bus.mem_we}, {31'd0, weexp});
        if (rst) begin
            check_val("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
            check_val("rst_din", bus.mem_din, 32'd0);
        end else if (m_stall) begin
            check_val("rmw_addr", {22'd0, bus.mem_addr}, {22'd0, m_addr});
            check_val("rmw_din", bus.mem_din, merged);
        end else if (ei) begin
            check_val("f_addr", {22'd0, bus.mem_addr}, {22'd0, bus.i_addr});
        end else if (ed) begin
            check_val("d_addr", {22'd0, bus.mem_addr}, {22'd0, bus.d_addr});
            if (weexp) check_val("st_din", bus.mem_din, bus.d_wdata);
        end

        // Predict next cycle and commit writes of this cycle.
        m_pv_i      = ei;
        m_pv_i_data = ref_mem[bus.i_addr];
        m_pv_d      = (ed && !(bus.d_we && part)) || (m_stall && !rst);
        m_pv_d_load = ed && !bus.d_we;
        m_pv_d_data = ref_mem[bus.d_addr];
        if (m_stall && !rst) ref_mem[m_addr] = merged;
        if (ed && bus.d_we && bus.d_be == 4'hF) ref_mem[bus.d_addr] = bus.d_wdata;
        m_stall = ed && bus.d_we && part;
        if (m_stall) begin
            m_addr  = bus.d_addr;
            m_be    = bus.d_be;
            m_wdata = bus.d_wdata;
        end
        if (rst) m_last_data = 1'b1;
        else if (ei) m_last_data = 1'b0;
        else if (ed) m_last_data = 1'b1;
        g_i = ei;
        g_d = ed;
        @(posedge clk);
        #1;
    endtask

    task automatic d_op(input logic we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_be    = be;
        bus.d_addr  = a;
        bus.d_wdata = wd;
    endtask

    logic [3:0] be_tab [6];

    initial begin
        logic [31:0] w;
        n_total = 0;
        n_bad   = 0;
        be_tab  = '{4'h0, 4'hF, 4'h1, 4'h3, 4'hC, 4'h6};
        rst = 1'b1;
        pl_en = 1'b0; pl_addr = 10'd0; pl_data = 32'd0;
        bus.i_req = 1'b0; bus.i_addr = 10'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 10'd0; bus.d_wdata = 32'd0;
        m_last_data = 1'b1; m_stall = 1'b0; m_addr = 10'd0; m_be = 4'h0; m_wdata = 32'd0;
        m_pv_i = 1'b0; m_pv_d = 1'b0; m_pv_d_load = 1'b0; m_pv_i_data = 32'd0; m_pv_d_data = 32'd0;
        g_i = 1'b0; g_d = 1'b0;

        // Preload memory and shadow copy while in reset.
        @(posedge clk); #1;
        for (int i = 0; i < 1024; i++) begin
            case (i)
                5:       w = 32'hff5ff06f;
                16:      w = 32'hCAFEF00D;
                32:      w = 32'h01020304;
                1020:    w = 32'h11223344;
                default: w = $urandom;
            endcase
            pl_en = 1'b1; pl_addr = i[9:0]; pl_data = w; ref_mem[i] = w;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        // Reset held 3 cycles with both requests pending.
        bus.i_req = 1'b1; bus.i_addr = 10'd5;
        d_op(1'b0, 4'h0, 10'd32, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_val("rst_gnt", {30'd0, snap_i_gnt, snap_d_gnt}, 32'd0);
            check_val("rst_we", {31'd0, snap_mem_we}, 32'd0);
        end
        rst = 1'b0;

        // Contention: fetch first, then strict alternation.
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_val("cont_i", {31'd0, snap_i_gnt}, {31'd0, (k % 2 == 0)});
            check_val("cont_d", {31'd0, snap_d_gnt}, {31'd0, (k % 2 == 1)});
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        cycle();

        // Fetch of word 5.
        bus.i_req = 1'b1; bus.i_addr = 10'd5;
        cycle();
        check_val("fetch_gnt", {31'd0, snap_i_gnt}, 32'd1);
        bus.i_req = 1'b0;
        cycle();
        check_val("fetch_rv", {31'd0, snap_i_rvalid}, 32'd1);
        check_val("fetch_data", snap_i_rdata, 32'hff5ff06f);

        // Byte store to 0x3FC with a fetch arriving during RMW.
        d_op(1'b1, 4'b0001, 10'h3FC, 32'h000000AA);
        cycle();
        check_val("bs_we_n", {31'd0, snap_mem_we}, 32'd0);
        bus.d_req = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 10'd5;
        cycle();
        check_val("bs_we_n1", {31'd0, snap_mem_we}, 32'd1);
        check_val("bs_din", snap_mem_din, 32'h112233AA);
        check_val("bs_stall", {31'd0, snap_i_gnt}, 32'd0);
        cycle();
        check_val("bs_rv", {31'd0, snap_d_rvalid}, 32'd1);
        check_val("bs_fgnt", {31'd0, snap_i_gnt}, 32'd1);
        bus.i_req = 1'b0;
        d_op(1'b0, 4'h0, 10'h3FC, 32'd0);
        cycle();
        bus.d_req = 1'b0;
        cycle();
        check_val("bs_rd", snap_d_rdata, 32'h112233AA);

        // Full store then readback.
        d_op(1'b1, 4'hF, 10'd32, 32'hDEADBEEF);
        cycle();
        check_val("fs_we", {31'd0, snap_mem_we}, 32'd1);
        bus.d_req = 1'b0;
        cycle();
        check_val("fs_rv", {31'd0, snap_d_rvalid}, 32'd1);
        d_op(1'b0, 4'h0, 10'd32, 32'd0);
        cycle();
        bus.d_req = 1'b0;
        cycle();
        check_val("fs_rd", snap_d_rdata, 32'hDEADBEEF);

        // No-op store then readback.
        d_op(1'b1, 4'h0, 10'd32, 32'h12345678);
        cycle();
        check_val("ns_we", {31'd0, snap_mem_we}, 32'd0);
        bus.d_req = 1'b0;
        cycle();
        check_val("ns_rv", {31'd0, snap_d_rvalid}, 32'd1);
        d_op(1'b0, 4'h0, 10'd32, 32'd0);
        cycle();
        bus.d_req = 1'b0;
        cycle();
        check_val("ns_rd", snap_d_rdata, 32'hDEADBEEF);

        // Reset during RMW cancels the write and the response.
        d_op(1'b1, 4'b0011, 10'd16, 32'h00005555);
        cycle();
        bus.d_req = 1'b0;
        rst = 1'b1;
        cycle();
        check_val("rr_we", {31'd0, snap_mem_we}, 32'd0);
        rst = 1'b0;
        cycle();
        check_val("rr_rv", {31'd0, snap_d_rvalid}, 32'd0);
        d_op(1'b0, 4'h0, 10'd16, 32'd0);
        cycle();
        check_val("rr_gnt", {31'd0, snap_d_gnt}, 32'd1);
        bus.d_req = 1'b0;
        cycle();
        check_val("rr_rd", snap_d_rdata, 32'hCAFEF00D);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (g_i || !bus.i_req) begin
                bus.i_req  = ($urandom_range(0, 2) != 0);
                bus.i_addr = 10'($urandom_range(0, 15));
            end
            if (g_d || !bus.d_req) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = $urandom_range(0, 1) == 1;
                bus.d_be    = be_tab[$urandom_range(0, 5)];
                bus.d_addr  = 10'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
